// File: rtl/rf_pkg.sv
// Shared types and default sizing for the scoreboarded integer register file.
package rf_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned AW_DEF       = $clog2(NUM_REGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/register_file_sb_if.sv
// ID-stage register file bus: read ports, writeback port, reservation and flush.
interface register_file_sb_if
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NUM_RD   = 2
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [XLEN-1:0]        wr_data;
    logic                   rsv_en;
    logic [AW-1:0]          rsv_addr;
    logic                   flush;
    logic [AW:0]            busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        output rd_data, rd_busy, busy_cnt
    );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: x0 squash, optional writeback bypass, busy masking.
module rf_read_port #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] reg_data,
    input  logic            reg_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic [XLEN-1:0] data_c,
    output logic            busy_c
);

    logic is_x0;
    logic wr_hit;
    logic rsv_hit;

    // A same-cycle writeback retires the producer unless a newer one reserves the register.
    always_comb begin
        is_x0   = (addr == '0);
        wr_hit  = wr_en && (wr_addr == addr);
        rsv_hit = rsv_en && (rsv_addr == addr);
        data_c  = reg_data;
        busy_c  = reg_busy && !(wr_hit && !rsv_hit);
        if (is_x0) begin
            data_c = '0;
            busy_c = 1'b0;
        end else if ((BYPASS != 0) && wr_hit) begin
            data_c = wr_data;
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// Flop-based integer register file with per-register busy scoreboard and busy count.
module register_file_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned INIT_IDX = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic               clk,
    input  logic               rst,
    register_file_sb_if.slave  bus
);

    localparam int unsigned AW = $clog2(NUM_REGS);
    localparam int unsigned CW = AW + 1;

    if ((NUM_RD < 1) || (NUM_RD > 4) || (NUM_REGS < 2) ||
        ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_bad_param
        $error("register_file_sb: NUM_RD must be 1..4 and NUM_REGS a power of two >= 2");
    end

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_nxt;

    // Data storage; x0 is only ever written by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (INIT_IDX != 0) ? XLEN'(i) : '0;
            end
        end else if (bus.wr_en && (bus.wr_addr != '0)) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Flush beats reservation, reservation beats writeback of an older producer.
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (bus.flush) begin
                busy_nxt[r] = 1'b0;
            end else if (bus.rsv_en && (bus.rsv_addr == AW'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if (bus.wr_en && (bus.wr_addr == AW'(r))) begin
                busy_nxt[r] = 1'b0;
            end
        end
        busy_nxt[0] = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= '0;
            cnt_q <= '0;
        end else begin
            busy  <= busy_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    assign bus.busy_cnt = cnt_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy_bit;

        assign addr = bus.rd_addr[p*AW +: AW];

        rf_read_port #(
            .XLEN   (XLEN),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_port (
            .addr     (addr),
            .reg_data (regs[addr]),
            .reg_busy (busy[addr]),
            .wr_en    (bus.wr_en),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .rsv_en   (bus.rsv_en),
            .rsv_addr (bus.rsv_addr),
            .data_c   (data),
            .busy_c   (busy_bit)
        );

        assign bus.rd_data[p*XLEN +: XLEN] = data;
        assign bus.rd_busy[p]              = busy_bit;
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed scenarios then random traffic against an array model.
`timescale 1ns/1ps
module tb_register_file_sb;
    import rf_pkg::*;

    localparam int unsigned NR  = NUM_REGS_DEF;
    localparam int unsigned XL  = XLEN_DEF;
    localparam int unsigned AW  = $clog2(NR);
    localparam int unsigned NRD = 2;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    xword_t m_regs [NR];
    bit     m_busy [NR];

    register_file_sb_if #(.XLEN(XL), .NUM_REGS(NR), .NUM_RD(NRD)) rf_if ();
    register_file_sb_if #(.XLEN(XL), .NUM_REGS(NR), .NUM_RD(NRD)) nb_if ();

    register_file_sb #(.XLEN(XL), .NUM_REGS(NR), .NUM_RD(NRD), .INIT_IDX(1), .BYPASS(1)) dut (
        .clk (clk), .rst (rst), .bus (rf_if.slave)
    );
    register_file_sb #(.XLEN(XL), .NUM_REGS(NR), .NUM_RD(NRD), .INIT_IDX(1), .BYPASS(0)) dut_nb (
        .clk (clk), .rst (rst), .bus (nb_if.slave)
    );

    // The no-bypass instance sees exactly the same stimulus.
    assign nb_if.rd_addr  = rf_if.rd_addr;
    assign nb_if.wr_en    = rf_if.wr_en;
    assign nb_if.wr_addr  = rf_if.wr_addr;
    assign nb_if.wr_data  = rf_if.wr_data;
    assign nb_if.rsv_en   = rf_if.rsv_en;
    assign nb_if.rsv_addr = rf_if.rsv_addr;
    assign nb_if.flush    = rf_if.flush;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = XL'(i);
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic we, input int wa, input xword_t wd, input logic re,
                         input int ra, input logic fl, input int a0, input int a1);
        rf_if.wr_en    = we;
        rf_if.wr_addr  = AW'(wa);
        rf_if.wr_data  = wd;
        rf_if.rsv_en   = re;
        rf_if.rsv_addr = AW'(ra);
        rf_if.flush    = fl;
        rf_if.rd_addr  = {AW'(a1), AW'(a0)};
    endtask

    function automatic int port_addr(input int p);
        logic [NRD*AW-1:0] v;
        v = rf_if.rd_addr;
        return int'(v[p*AW +: AW]);
    endfunction

    function automatic xword_t exp_data(input int a, input bit bypass);
        if (a == 0) return '0;
        if (bypass && rf_if.wr_en && (int'(rf_if.wr_addr) == a)) return rf_if.wr_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input int a);
        bit retiring;
        if (a == 0) return 1'b0;
        retiring = rf_if.wr_en && (int'(rf_if.wr_addr) == a) &&
                   !(rf_if.rsv_en && (int'(rf_if.rsv_addr) == a));
        return m_busy[a] && !retiring;
    endfunction

    function automatic int popcount();
        int c = 0;
        for (int i = 0; i < NR; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    // Architectural effect of one clock edge, applied to the model.
    task automatic model_edge();
        if (rf_if.wr_en && (rf_if.wr_addr != '0)) m_regs[rf_if.wr_addr] = rf_if.wr_data;
        if (rf_if.flush) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        end else begin
            if (rf_if.wr_en)  m_busy[rf_if.wr_addr]  = 1'b0;
            if (rf_if.rsv_en) m_busy[rf_if.rsv_addr] = 1'b1;
        end
        m_busy[0] = 1'b0;
    endtask

    task automatic check_reads();
        for (int p = 0; p < NRD; p++) begin
            int a;
            a = port_addr(p);
            check($sformatf("rd_data%0d_a%0d", p, a),
                  64'(rf_if.rd_data[p*XL +: XL]), 64'(exp_data(a, 1'b1)));
            check($sformatf("nb_rd_data%0d_a%0d", p, a),
                  64'(nb_if.rd_data[p*XL +: XL]), 64'(exp_data(a, 1'b0)));
            check($sformatf("rd_busy%0d_a%0d", p, a), 64'(rf_if.rd_busy[p]), 64'(exp_busy(a)));
            check($sformatf("nb_rd_busy%0d_a%0d", p, a), 64'(nb_if.rd_busy[p]), 64'(exp_busy(a)));
        end
    endtask

    // Inputs are applied at the falling edge; reads are checked before the rising edge.
    task automatic cycle();
        #1;
        check_reads();
        @(posedge clk);
        model_edge();
        #1;
        check("busy_cnt", 64'(rf_if.busy_cnt), 64'(popcount()));
        check("nb_busy_cnt", 64'(nb_if.busy_cnt), 64'(popcount()));
        @(negedge clk);
    endtask

    function automatic int rand_addr();
        return ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NR - 1));
    endfunction

    initial begin
        rst = 1'b1;
        drive(0, 0, '0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset contents and idle scoreboard
        drive(0, 0, '0, 0, 0, 0, 5, 31);
        #1;
        check("t1_r5", 64'(rf_if.rd_data[XL-1:0]), 64'd5);
        check("t1_r31", 64'(rf_if.rd_data[2*XL-1:XL]), 64'd31);
        check("t1_busy", 64'(rf_if.rd_busy), 64'd0);
        check("t1_cnt", 64'(rf_if.busy_cnt), 64'd0);
        cycle();

        // Same-cycle write/read of r3, with and without bypass
        drive(1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 3);
        #1;
        check("t2_bypass", 64'(rf_if.rd_data[XL-1:0]), 64'hDEADBEEF);
        check("t2_nobypass_old", 64'(nb_if.rd_data[XL-1:0]), 64'd3);
        cycle();
        drive(0, 0, '0, 0, 0, 0, 3, 3);
        #1;
        check("t2_nobypass_new", 64'(nb_if.rd_data[XL-1:0]), 64'hDEADBEEF);
        cycle();

        // x0 is immutable and never busy
        drive(1, 0, 32'h1234, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, '0, 1, 0, 0, 0, 0);
        #1;
        check("t3_r0_data", 64'(rf_if.rd_data[XL-1:0]), 64'd0);
        check("t3_r0_busy", 64'(rf_if.rd_busy[0]), 64'd0);
        cycle();
        check("t3_cnt", 64'(rf_if.busy_cnt), 64'd0);

        // Re-reservation wins over writeback of the older producer
        drive(0, 0, '0, 1, 7, 0, 7, 0);
        cycle();
        check("t4_cnt_rsv", 64'(rf_if.busy_cnt), 64'd1);
        drive(1, 7, 32'd77, 1, 7, 0, 7, 0);
        #1;
        check("t4_busy_held", 64'(rf_if.rd_busy[0]), 64'd1);
        cycle();
        check("t4_cnt_held", 64'(rf_if.busy_cnt), 64'd1);
        drive(1, 7, 32'd88, 0, 0, 0, 7, 0);
        #1;
        check("t4_busy_wb", 64'(rf_if.rd_busy[0]), 64'd0);
        check("t4_data_wb", 64'(rf_if.rd_data[XL-1:0]), 64'd88);
        cycle();
        check("t4_cnt_clear", 64'(rf_if.busy_cnt), 64'd0);

        // Count up, then flush squashes the same-cycle reservation
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, '0, 1, i, 0, i, 0);
            cycle();
            check($sformatf("t5_cnt_%0d", i), 64'(rf_if.busy_cnt), 64'(i));
        end
        drive(0, 0, '0, 1, 4, 1, 1, 4);
        cycle();
        check("t5_cnt_flush", 64'(rf_if.busy_cnt), 64'd0);
        drive(0, 0, '0, 0, 0, 0, 1, 4);
        #1;
        check("t5_busy_flush", 64'(rf_if.rd_busy), 64'd0);
        cycle();

        // Asynchronous reset between clock edges
        drive(0, 0, '0, 1, 9, 0, 9, 3);
        cycle();
        check("t6_cnt_pre", 64'(rf_if.busy_cnt), 64'd1);
        drive(0, 0, '0, 0, 0, 0, 9, 3);
        #1;
        check("t6_busy_pre", 64'(rf_if.rd_busy[0]), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_cnt_rst", 64'(rf_if.busy_cnt), 64'd0);
        check("t6_r9_rst", 64'(rf_if.rd_data[XL-1:0]), 64'd9);
        check("t6_r3_rst", 64'(rf_if.rd_data[2*XL-1:XL]), 64'd3);
        check("t6_busy_rst", 64'(rf_if.rd_busy), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic with address collisions biased toward low registers
        for (int n = 0; n < 400; n++) begin
            drive(logic'($urandom_range(0, 3) != 0), rand_addr(), xword_t'($urandom),
                  logic'($urandom_range(0, 2) != 0), rand_addr(),
                  logic'($urandom_range(0, 19) == 0), rand_addr(), rand_addr());
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
